// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-master to 1-slave Wishbone B3 arbiter.
// Supports round-robin or fixed-priority selection. A grant stays locked for as long as the
// owner holds cyc. A bus watchdog ends a hung transfer with err.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock and synchronous active-low reset
//   wbm_*_i / wbm_*_o           packed per-master Wishbone buses (master k in slice k)
//   wbs_*_o / wbs_*_i           shared slave port, driven by the granted master
//   gnt_o                       registered one-hot grant, zero when idle
//   timeout_o                   one-cycle pulse when the watchdog aborts a transfer
module wb_arbiter_rr #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned PRIO_MODE   = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_n_i,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0]     wbm_adr_i,
  input  logic [DATA_WIDTH*NUM_MASTERS-1:0]     wbm_dat_i,
  input  logic [(DATA_WIDTH/8)*NUM_MASTERS-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]                wbm_we_i,
  input  logic [NUM_MASTERS-1:0]                wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]                wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]              wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]              wbm_bte_i,
  output logic [DATA_WIDTH*NUM_MASTERS-1:0]     wbm_dat_o,
  output logic [NUM_MASTERS-1:0]                wbm_ack_o,
  output logic [NUM_MASTERS-1:0]                wbm_err_o,
  output logic [NUM_MASTERS-1:0]                wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]                 wbs_adr_o,
  output logic [DATA_WIDTH-1:0]                 wbs_dat_o,
  output logic [DATA_WIDTH/8-1:0]               wbs_sel_o,
  output logic                                  wbs_we_o,
  output logic                                  wbs_cyc_o,
  output logic                                  wbs_stb_o,
  output logic [2:0]                            wbs_cti_o,
  output logic [1:0]                            wbs_bte_o,
  input  logic [DATA_WIDTH-1:0]                 wbs_dat_i,
  input  logic                                  wbs_ack_i,
  input  logic                                  wbs_err_i,
  input  logic                                  wbs_rty_i,
  output logic [NUM_MASTERS-1:0]                gnt_o,
  output logic                                  timeout_o
);

  localparam int unsigned SelW = DATA_WIDTH / 8;
  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IdxW-1:0]        ptr_q;
  logic [CntW-1:0]        wd_cnt_q;

  logic [NUM_MASTERS-1:0] win_oh;
  logic [IdxW-1:0]        win_idx;
  logic                   any_req;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   term;
  logic                   wd_fire;
  int                     cand;

  // Winner search. Loops run from the far end down so that the last hit is the nearest one.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    cand    = 0;
    any_req = |wbm_cyc_i;
    if (PRIO_MODE == 1) begin
      for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
        if (wbm_cyc_i[k]) begin
          win_oh    = '0;
          win_oh[k] = 1'b1;
          win_idx   = IdxW'(k);
        end
      end
    end else begin
      for (int i = int'(NUM_MASTERS); i >= 1; i--) begin
        cand = (int'(ptr_q) + i) % int'(NUM_MASTERS);
        if (wbm_cyc_i[cand]) begin
          win_oh       = '0;
          win_oh[cand] = 1'b1;
          win_idx      = IdxW'(cand);
        end
      end
    end
  end

  // Forward path: AND-OR mux on the one-hot grant, so everything is zero while idle.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      wbs_adr_o |= {ADDR_WIDTH{gnt_q[k]}} & wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      wbs_dat_o |= {DATA_WIDTH{gnt_q[k]}} & wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      wbs_sel_o |= {SelW{gnt_q[k]}} & wbm_sel_i[k*SelW +: SelW];
      wbs_we_o  |= gnt_q[k] & wbm_we_i[k];
      wbs_cti_o |= {3{gnt_q[k]}} & wbm_cti_i[k*3 +: 3];
      wbs_bte_o |= {2{gnt_q[k]}} & wbm_bte_i[k*2 +: 2];
      own_cyc   |= gnt_q[k] & wbm_cyc_i[k];
      own_stb   |= gnt_q[k] & wbm_stb_i[k];
    end
  end

  // A real termination in the limit cycle wins over the watchdog.
  assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wd_fire = (TIMEOUT != 0) && (state_q == StGrant) &&
                   (wd_cnt_q == CntW'(TIMEOUT)) && !term;

  assign wbs_cyc_o = own_cyc & ~wd_fire;
  assign wbs_stb_o = own_stb & ~wd_fire;
  assign wbm_ack_o = gnt_q & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = gnt_q & {NUM_MASTERS{wbs_err_i | wd_fire}};
  assign wbm_rty_o = gnt_q & {NUM_MASTERS{wbs_rty_i}};
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign gnt_o     = gnt_q;
  assign timeout_o = wd_fire;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      ptr_q    <= LastIdx;
      wd_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wd_cnt_q <= '0;
          if (any_req) begin
            state_q <= StGrant;
            gnt_q   <= win_oh;
            if (PRIO_MODE == 0) ptr_q <= win_idx;
          end
        end
        StGrant: begin
          if (!own_cyc) begin
            // Owner released: one idle cycle before the next grant.
            state_q  <= StIdle;
            gnt_q    <= '0;
            wd_cnt_q <= '0;
          end else if (wd_fire || term) begin
            wd_cnt_q <= '0;
          end else if (own_stb && (TIMEOUT != 0)) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr. Two instances share the stimulus: inst a is round-robin with an
// 8-cycle watchdog, inst b is fixed priority with the watchdog disabled.
module tb_wb_arbiter_rr;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;
  localparam int TO_A = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] dat;
  logic [N*SW-1:0] sel;
  logic [N-1:0]  we, cyc, stb;
  logic [3*N-1:0] cti;
  logic [2*N-1:0] bte;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty;

  logic [N*DW-1:0] a_mdat, b_mdat;
  logic [N-1:0]  a_ack, a_err, a_rty, a_gnt, b_ack, b_err, b_rty, b_gnt;
  logic [AW-1:0] a_sadr, b_sadr;
  logic [DW-1:0] a_sdat, b_sdat;
  logic [SW-1:0] a_ssel, b_ssel;
  logic          a_swe, a_scyc, a_sstb, a_to, b_swe, b_scyc, b_sstb, b_to;
  logic [2:0]    a_scti, b_scti;
  logic [1:0]    a_sbte, b_sbte;

  int checks = 0;
  int failures = 0;

  wb_arbiter_rr #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO_MODE(0),
                  .TIMEOUT(TO_A)) u_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we), .wbm_cyc_i(cyc),
    .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(a_mdat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
    .wbs_adr_o(a_sadr), .wbs_dat_o(a_sdat), .wbs_sel_o(a_ssel), .wbs_we_o(a_swe),
    .wbs_cyc_o(a_scyc), .wbs_stb_o(a_sstb), .wbs_cti_o(a_scti), .wbs_bte_o(a_sbte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .gnt_o(a_gnt), .timeout_o(a_to)
  );

  wb_arbiter_rr #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO_MODE(1),
                  .TIMEOUT(0)) u_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we), .wbm_cyc_i(cyc),
    .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(b_mdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
    .wbs_adr_o(b_sadr), .wbs_dat_o(b_sdat), .wbs_sel_o(b_ssel), .wbs_we_o(b_swe),
    .wbs_cyc_o(b_scyc), .wbs_stb_o(b_sstb), .wbs_cti_o(b_scti), .wbs_bte_o(b_sbte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .gnt_o(b_gnt), .timeout_o(b_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    adr = '0; dat = '0; sel = '0; we = '0; cyc = '0; stb = '0; cti = '0; bte = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0;
    cyc = '1;
    stb = '1;
    tick();
    tick();
    #1;
    checks++; if (a_gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt_a got=%b exp=000", a_gnt); end
    checks++; if (b_gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt_b got=%b exp=000", b_gnt); end
    checks++; if ({a_scyc, a_sstb, a_to} !== 3'b000) begin failures++; $display("FAIL reset_slave got=%b exp=000", {a_scyc, a_sstb, a_to}); end
    checks++; if ({a_ack, a_err, a_rty} !== 9'b0) begin failures++; $display("FAIL reset_term got=%b exp=0", {a_ack, a_err, a_rty}); end
    rst_n = 1'b1;
    tick();
    #1;
    checks++; if (a_gnt !== 3'b001) begin failures++; $display("FAIL reset_first_rr got=%b exp=001", a_gnt); end
    checks++; if (b_gnt !== 3'b001) begin failures++; $display("FAIL reset_first_prio got=%b exp=001", b_gnt); end
  endtask

  task automatic test_single();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1*AW +: AW] = 16'h1111;
    dat[1*DW +: DW] = 32'hCAFE_0001;
    #1;
    checks++; if ({a_gnt, a_scyc} !== 4'b0000) begin failures++; $display("FAIL single_latency got=%b exp=0000", {a_gnt, a_scyc}); end
    tick();
    #1;
    checks++; if (a_gnt !== 3'b010) begin failures++; $display("FAIL single_gnt got=%b exp=010", a_gnt); end
    checks++; if (a_scyc !== 1'b1) begin failures++; $display("FAIL single_cyc got=%b exp=1", a_scyc); end
    checks++; if ({a_sadr, a_sdat, a_swe} !== {16'h1111, 32'hCAFE_0001, 1'b1}) begin failures++; $display("FAIL single_fwd got=%h/%h/%b exp=1111/cafe0001/1", a_sadr, a_sdat, a_swe); end
    tick();
    tick();
    s_ack = 1'b1;
    s_dat = 32'h1234_5678;
    #1;
    checks++; if (a_ack !== 3'b010) begin failures++; $display("FAIL single_ack_a got=%b exp=010", a_ack); end
    checks++; if (b_ack !== 3'b010) begin failures++; $display("FAIL single_ack_b got=%b exp=010", b_ack); end
    checks++; if (a_mdat[1*DW +: DW] !== 32'h1234_5678) begin failures++; $display("FAIL single_rdata got=%h exp=12345678", a_mdat[1*DW +: DW]); end
    tick();
    clr();
  endtask

  // Masters in mask request continuously; each drops cyc for drop_len cycles after its ack.
  // exp_seq holds six expected owners, two bits each, first owner in the low bits.
  task automatic test_rotation(input string name, input bit use_b, input logic [N-1:0] mask,
                               input int drop_len, input logic [11:0] exp_seq);
    int down[N];
    int age;
    int gap;
    int owner;
    int seen[$];
    int gaps[$];
    logic [N-1:0] g, prev_g;
    do_reset();
    for (int k = 0; k < N; k++) down[k] = 0;
    age = 0; gap = 0; prev_g = '0;
    for (int t = 0; t < 34; t++) begin
      for (int k = 0; k < N; k++) begin
        cyc[k] = mask[k] && (down[k] == 0);
        stb[k] = cyc[k];
      end
      g = use_b ? b_gnt : a_gnt;
      if (g != 0 && g == prev_g) age++; else age = 0;
      s_ack = (g != 0) && (age == 1);
      owner = -1;
      for (int k = 0; k < N; k++) if (g[k]) owner = k;
      if (g != 0 && g != prev_g) begin
        seen.push_back(owner);
        gaps.push_back(gap);
        gap = 0;
      end
      if (g == 0) gap++;
      for (int k = 0; k < N; k++) if (down[k] > 0) down[k]--;
      if (s_ack && owner >= 0) down[owner] = drop_len;
      prev_g = g;
      tick();
    end
    checks++;
    if (seen.size() < 6) begin
      failures++;
      $display("FAIL %s_count got=%0d owners exp=6 or more", name, seen.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seen[i] != int'(exp_seq[i*2 +: 2])) begin
          failures++;
          $display("FAIL %s_order[%0d] got=%0d exp=%0d", name, i, seen[i], exp_seq[i*2 +: 2]);
        end
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (gaps[i] != 1) begin
          failures++;
          $display("FAIL %s_gap[%0d] got=%0d idle cycles exp=1", name, i, gaps[i]);
        end
      end
    end
    clr();
  endtask

  task automatic test_fixed_starve();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      s_ack = (i % 2 == 1);
      #1;
      checks++; if (b_gnt !== 3'b001) begin failures++; $display("FAIL starve_gnt[%0d] got=%b exp=001", i, b_gnt); end
      tick();
    end
    clr();
  endtask

  task automatic test_burst_lock();
    logic [2:0] c;
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    cti[0 +: 3] = 3'b010;
    tick();
    for (int b = 0; b < 4; b++) begin
      c = (b == 3) ? 3'b111 : 3'b010;
      cti[0 +: 3] = c;
      adr[0 +: AW] = AW'(16'h0100 + 4 * b);
      s_ack = 1'b1;
      #1;
      checks++; if (a_gnt !== 3'b001) begin failures++; $display("FAIL burst_gnt[%0d] got=%b exp=001", b, a_gnt); end
      checks++; if (a_ack !== 3'b001) begin failures++; $display("FAIL burst_ack[%0d] got=%b exp=001", b, a_ack); end
      checks++; if (a_scti !== c) begin failures++; $display("FAIL burst_cti[%0d] got=%b exp=%b", b, a_scti, c); end
      tick();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
    #1;
    checks++; if ({a_gnt, a_scyc} !== 4'b0010) begin failures++; $display("FAIL burst_release got=%b exp=0010", {a_gnt, a_scyc}); end
    tick();
    #1;
    checks++; if (a_gnt !== 3'b000) begin failures++; $display("FAIL burst_idle got=%b exp=000", a_gnt); end
    tick();
    #1;
    checks++; if (a_gnt !== 3'b010) begin failures++; $display("FAIL burst_next got=%b exp=010", a_gnt); end
    clr();
  endtask

  task automatic test_watchdog();
    logic fire;
    do_reset();
    cyc[2] = 1'b1; stb[2] = 1'b1;
    tick();
    for (int i = 1; i <= 18; i++) begin
      s_ack = (i == 18);
      fire = (i == 9);
      #1;
      checks++; if (a_err !== (fire ? 3'b100 : 3'b000)) begin failures++; $display("FAIL wd_err[%0d] got=%b exp=%b", i, a_err, fire ? 3'b100 : 3'b000); end
      checks++; if (a_to !== fire) begin failures++; $display("FAIL wd_pulse[%0d] got=%b exp=%b", i, a_to, fire); end
      checks++; if ({a_scyc, a_sstb} !== {!fire, !fire}) begin failures++; $display("FAIL wd_cyc[%0d] got=%b exp=%b", i, {a_scyc, a_sstb}, {!fire, !fire}); end
      checks++; if (a_gnt !== 3'b100) begin failures++; $display("FAIL wd_gnt[%0d] got=%b exp=100", i, a_gnt); end
      checks++; if ({b_err, b_to} !== 4'b0000) begin failures++; $display("FAIL wd_disabled[%0d] got=%b exp=0000", i, {b_err, b_to}); end
      if (i == 18) begin
        checks++; if (a_ack !== 3'b100) begin failures++; $display("FAIL wd_ack_wins got=%b exp=100", a_ack); end
      end
      tick();
    end
    clr();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; cti[3 +: 3] = 3'b010;
    tick();
    s_ack = 1'b1;
    #1;
    checks++; if (a_gnt !== 3'b010) begin failures++; $display("FAIL rstmid_gnt got=%b exp=010", a_gnt); end
    tick();
    rst_n = 1'b0;
    tick();
    #1;
    checks++; if ({a_gnt, a_scyc} !== 4'b0000) begin failures++; $display("FAIL rstmid_drop got=%b exp=0000", {a_gnt, a_scyc}); end
    checks++; if (a_ack !== 3'b000) begin failures++; $display("FAIL rstmid_noterm got=%b exp=000", a_ack); end
    rst_n = 1'b1;
    s_ack = 1'b0;
    cyc = '1;
    stb = '1;
    tick();
    #1;
    checks++; if (a_gnt !== 3'b001) begin failures++; $display("FAIL rstmid_ptr got=%b exp=001", a_gnt); end
    clr();
  endtask

  // Reference model: per instance, the current owner (-1 when idle), the last-grant index
  // and the number of unanswered strobe cycles.
  task automatic test_random();
    int m_owner[2], m_ptr[2], m_cnt[2];
    int own, lim, win, c;
    logic term, fire;
    logic [N-1:0] e_gnt, e_ack, e_err, e_rty, g_act, ack_act, err_act, rty_act;
    logic e_cyc, e_stb, cyc_act, stb_act, to_act, we_act;
    logic [AW-1:0] adr_act;
    logic [DW-1:0] dat_act;
    logic [SW-1:0] sel_act;
    logic [2:0] cti_act;
    logic [1:0] bte_act;
    logic [N*DW-1:0] mdat_act;
    bit quiet;
    do_reset();
    for (int d = 0; d < 2; d++) begin m_owner[d] = -1; m_ptr[d] = N - 1; m_cnt[d] = 0; end
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < N; k++) begin
        if (cyc[k] && ($urandom % 8 == 0)) cyc[k] = 1'b0;
        else if (!cyc[k] && ($urandom % 3 == 0)) cyc[k] = 1'b1;
        stb[k] = cyc[k] && ($urandom % 4 != 0);
      end
      adr = (N*AW)'({$urandom, $urandom});
      dat = (N*DW)'({$urandom, $urandom, $urandom});
      sel = (N*SW)'($urandom);
      we  = N'($urandom);
      cti = (3*N)'($urandom);
      bte = (2*N)'($urandom);
      s_dat = $urandom;
      quiet = (t % 100) >= 70;
      s_ack = !quiet && ($urandom % 4 == 0);
      s_err = !quiet && ($urandom % 16 == 0);
      s_rty = !quiet && ($urandom % 16 == 0);
      rst_n = !(t % 250 == 249);
      #1;
      for (int d = 0; d < 2; d++) begin
        own = m_owner[d];
        lim = (d == 0) ? TO_A : 0;
        term = s_ack | s_err | s_rty;
        fire = (lim > 0) && (own >= 0) && (m_cnt[d] == lim) && !term;
        e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_cyc = 1'b0; e_stb = 1'b0;
        if (own >= 0) begin
          e_gnt[own] = 1'b1;
          e_ack[own] = s_ack;
          e_err[own] = s_err | fire;
          e_rty[own] = s_rty;
          e_cyc = cyc[own] && !fire;
          e_stb = stb[own] && !fire;
        end
        if (d == 0) begin
          g_act = a_gnt; ack_act = a_ack; err_act = a_err; rty_act = a_rty; cyc_act = a_scyc;
          stb_act = a_sstb; to_act = a_to; adr_act = a_sadr; dat_act = a_sdat; sel_act = a_ssel;
          we_act = a_swe; cti_act = a_scti; bte_act = a_sbte; mdat_act = a_mdat;
        end else begin
          g_act = b_gnt; ack_act = b_ack; err_act = b_err; rty_act = b_rty; cyc_act = b_scyc;
          stb_act = b_sstb; to_act = b_to; adr_act = b_sadr; dat_act = b_sdat; sel_act = b_ssel;
          we_act = b_swe; cti_act = b_scti; bte_act = b_sbte; mdat_act = b_mdat;
        end
        checks++; if (g_act !== e_gnt) begin failures++; $display("FAIL rnd%0d_gnt t=%0d got=%b exp=%b", d, t, g_act, e_gnt); end
        checks++; if ({cyc_act, stb_act} !== {e_cyc, e_stb}) begin failures++; $display("FAIL rnd%0d_cycstb t=%0d got=%b exp=%b", d, t, {cyc_act, stb_act}, {e_cyc, e_stb}); end
        checks++; if ({ack_act, err_act, rty_act} !== {e_ack, e_err, e_rty}) begin failures++; $display("FAIL rnd%0d_term t=%0d got=%b exp=%b", d, t, {ack_act, err_act, rty_act}, {e_ack, e_err, e_rty}); end
        checks++; if (to_act !== fire) begin failures++; $display("FAIL rnd%0d_timeout t=%0d got=%b exp=%b", d, t, to_act, fire); end
        checks++; if (mdat_act !== {N{s_dat}}) begin failures++; $display("FAIL rnd%0d_rdata t=%0d got=%h exp=%h", d, t, mdat_act, {N{s_dat}}); end
        if (own >= 0) begin
          checks++;
          if ({adr_act, dat_act, sel_act, we_act, cti_act, bte_act} !==
              {adr[own*AW +: AW], dat[own*DW +: DW], sel[own*SW +: SW], we[own],
               cti[own*3 +: 3], bte[own*2 +: 2]}) begin
            failures++;
            $display("FAIL rnd%0d_fwd t=%0d owner=%0d got=%h/%h/%h/%b/%b/%b exp=%h/%h/%h/%b/%b/%b",
                     d, t, own, adr_act, dat_act, sel_act, we_act, cti_act, bte_act,
                     adr[own*AW +: AW], dat[own*DW +: DW], sel[own*SW +: SW], we[own],
                     cti[own*3 +: 3], bte[own*2 +: 2]);
          end
        end
        // Advance the model with this cycle's inputs.
        if (!rst_n) begin
          m_owner[d] = -1; m_ptr[d] = N - 1; m_cnt[d] = 0;
        end else if (own < 0) begin
          m_cnt[d] = 0;
          win = -1;
          if (d == 0) begin
            for (int i = 1; i <= N; i++) begin
              c = (m_ptr[d] + i) % N;
              if (win < 0 && cyc[c]) win = c;
            end
            if (win >= 0) m_ptr[d] = win;
          end else begin
            for (int k = 0; k < N; k++) if (win < 0 && cyc[k]) win = k;
          end
          m_owner[d] = win;
        end else if (!cyc[own]) begin
          m_owner[d] = -1; m_cnt[d] = 0;
        end else if (fire || term) begin
          m_cnt[d] = 0;
        end else if (stb[own] && lim > 0) begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
      tick();
    end
    rst_n = 1'b1;
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    test_reset();
    test_single();
    test_rotation("rr", 1'b0, 3'b111, 1, 12'b10_01_00_10_01_00);
    test_rotation("prio", 1'b1, 3'b101, 2, 12'b10_00_10_00_10_00);
    test_fixed_starve();
    test_burst_lock();
    test_watchdog();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Parametrised N-master to 1-slave Wishbone B3 arbiter; successor to the fixed single-mode memory arbiter.
- Sits in front of the shared memory port. Masters are per-core I/D buses plus debug, so NUM_MASTERS = 1+2*NUM_CORES.
- Adds selectable round-robin or fixed-priority arbitration, cycle-locked bursts, a bus-timeout watchdog that aborts hung transfers with err, and grant/timeout status outputs.

Parameters:
- NUM_MASTERS, 3, number of masters; legal range 1..16.
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, address width.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with master 0 highest.
- TIMEOUT, 255, watchdog limit in cycles; 0 disables the watchdog; counter width is clog2(TIMEOUT+1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  synchronous reset, active-low.
- wbm_adr_i  in  ADDR_WIDTH*NUM_MASTERS  master addresses; master k occupies bits [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH].
- wbm_dat_i  in  DATA_WIDTH*NUM_MASTERS  master write data.
- wbm_sel_i  in  (DATA_WIDTH/8)*NUM_MASTERS  byte selects.
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  write enable, cycle, strobe per master.
- wbm_cti_i  in  3*NUM_MASTERS  cycle type identifier.
- wbm_bte_i  in  2*NUM_MASTERS  burst type extension.
- wbm_dat_o  out  DATA_WIDTH*NUM_MASTERS  read data; slave data broadcast to every slice.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  per-master termination signals.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  slave-side widths  signals of the granted master.
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  slave-side widths  slave response.
- gnt_o  out  NUM_MASTERS  one-hot grant vector; all zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (wb_rst_n_i low at a clock edge):
  - state = IDLE, gnt_o = 0, timeout_o = 0, watchdog counter = 0.
  - Round-robin last-grant pointer = NUM_MASTERS-1, so master 0 wins first.
  - All wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o = 0.
  - Reset asserted mid-transfer drops wbs_cyc_o at the next edge; no termination is sent to the master.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If any wbm_cyc_i is high, the winner is registered into gnt_o at the next edge and the state moves to GRANT.
  - Slave sees cyc one cycle after the request (1-cycle arbitration latency).
- Winner selection:
  - PRIO_MODE=0: first requesting master searching upward from pointer+1 with wrap-around; the pointer updates to the winner when the grant is taken.
  - PRIO_MODE=1: lowest-index requesting master; pointer unused.
- GRANT, forward path (combinational from gnt_o):
  - Slave adr/dat/sel/we/cti/bte come from the granted slice.
  - wbs_cyc_o = granted cyc; wbs_stb_o = granted stb.
- GRANT, return path: slave ack/err/rty are routed only to the granted master; all other masters see 0.
- Grant hold:
  - The grant is held for as long as the granted wbm_cyc_i stays high, including across CTI bursts and stb-low gaps.
  - No preemption, even by a higher-priority request.
- Release:
  - Granted cyc low at an edge → IDLE at that edge, gnt_o = 0.
  - Earliest next grant is the following edge, giving one idle cycle between owners.
- Watchdog (TIMEOUT>0):
  - Counts cycles with wbs_stb_o high and no ack/err/rty; clears on any termination and in IDLE.
  - When the count equals TIMEOUT in GRANT: wbm_err_o of the owner = 1 for that cycle (combinational), wbs_cyc_o and wbs_stb_o forced 0 for that cycle, timeout_o pulses, counter clears.
  - Grant is not revoked; the master decides whether to drop cyc.
- A slave ack in the same cycle the watchdog reaches its limit takes precedence: ack is passed, no err, no timeout.
- NUM_MASTERS=1: grant still passes through IDLE→GRANT with the same 1-cycle latency.

Test Plan:
- Single request: master 1 asserts cyc/stb at cycle 0, slave acks at cycle 3 → gnt_o=3'b010 from cycle 1, wbm_ack_o[1]=1 at cycle 3, other acks 0.
- Round-robin fairness: NUM_MASTERS=3, all masters hold cyc for 2-cycle transactions continuously → grant order 0,1,2,0,1,2 with one idle cycle between owners.
- Fixed priority (PRIO_MODE=1): masters 2 and 0 request together, master 2 re-requests immediately after release → grant order 0,2,0,…; master 1 gets no grant while 0 keeps requesting.
- Burst lock: master 0 runs a 4-beat incrementing burst (cti=010, last beat 111) while master 1 requests → gnt_o stays 001 for all 4 acks; master 1 is granted 2 cycles after master 0 drops cyc.
- Watchdog: TIMEOUT=8, slave never acks → after 8 stb cycles wbm_err_o[owner]=1 and timeout_o=1 for exactly one cycle, wbs_cyc_o=0 that cycle; repeat with ack on cycle 8 → ack passed, no err.
- Reset mid-burst: wb_rst_n_i low during beat 2 → next edge wbs_cyc_o=0, gnt_o=0, pointer reset so master 0 wins the first post-reset tie among all masters.
